// File: rtl/shifter_pkg.sv
// Shared definitions for the shift/rotate unit: op encodings, FSM state type and
// an op-class helper. Also used by the ALU decoder.
package shifter_pkg;

    localparam int unsigned OP_W = 3;

    // op[0]=left, op[1]=arith, op[2]=rotate
    localparam logic [OP_W-1:0] OP_SRL = 3'b000;
    localparam logic [OP_W-1:0] OP_SLL = 3'b001;
    localparam logic [OP_W-1:0] OP_SRA = 3'b010;
    localparam logic [OP_W-1:0] OP_SLA = 3'b011;  // arith-left behaves as logical-left
    localparam logic [OP_W-1:0] OP_ROR = 3'b100;
    localparam logic [OP_W-1:0] OP_ROL = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // 11x encodings pass the operand through unchanged
    function automatic logic op_is_reserved(input logic [OP_W-1:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP bit positions.
// Ports:
//   value  : operand to shift
//   amount : bit positions to shift this step (0..STEP)
//   op     : operation encoding from shifter_pkg
//   result : shifted value
module shift_step
    import shifter_pkg::*;
#(
    parameter int unsigned SIZE = 32,
    parameter int unsigned STEP = 4
) (
    input  logic [SIZE-1:0]            value,
    input  logic [$clog2(STEP+1)-1:0]  amount,
    input  logic [OP_W-1:0]            op,
    output logic [SIZE-1:0]            result
);

    // Rotate: a shift by SIZE yields zero, so amount==0 wraps nothing.
    always_comb begin
        result = value;
        case (op)
            OP_SRL:         result = value >> amount;
            OP_SLL, OP_SLA: result = value << amount;
            OP_SRA:         result = $unsigned($signed(value) >>> amount);
            OP_ROR:         result = (value >> amount) | (value << (SIZE - amount));
            OP_ROL:         result = (value << amount) | (value >> (SIZE - amount));
            default:        result = value;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Multi-cycle shift/rotate unit: shifts at most STEP positions per cycle,
// valid/ready on both sides, synchronous kill for pipeline flush.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   kill                 : abort any operation in flight (next cycle IDLE)
//   in_valid/in_ready    : request handshake
//   in_data/in_shamt/in_op : operand, shift amount, op encoding
//   out_valid/out_ready  : result handshake
//   out_data             : result, held until the next result is produced
module iterative_shifter
    import shifter_pkg::*;
#(
    parameter int unsigned SIZE = 32,
    parameter int unsigned STEP = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     kill,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SIZE-1:0]          in_data,
    input  logic [$clog2(SIZE)-1:0]  in_shamt,
    input  logic [OP_W-1:0]          in_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE-1:0]          out_data
);

    localparam int unsigned SHAMT_W = $clog2(SIZE);
    localparam int unsigned AMT_W   = $clog2(STEP + 1);

    state_t               state_q;
    state_t               state_next;
    logic [SIZE-1:0]      data_q;
    logic [SIZE-1:0]      data_next;
    logic [OP_W-1:0]      op_q;
    logic [OP_W-1:0]      op_next;
    logic [SHAMT_W-1:0]   remaining_q;
    logic [SHAMT_W-1:0]   remaining_next;
    logic [SIZE-1:0]      out_data_next;
    logic                 in_ready_next;
    logic                 out_valid_next;
    logic [AMT_W-1:0]     step_amt;
    logic [SIZE-1:0]      step_result;

    // Single shared step unit working on the latched operand
    shift_step #(
        .SIZE (SIZE),
        .STEP (STEP)
    ) u_shift_step (
        .value  (data_q),
        .amount (step_amt),
        .op     (op_q),
        .result (step_result)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next state, datapath next values and registered handshake outputs
    always_comb begin
        state_next     = state_q;
        data_next      = data_q;
        op_next        = op_q;
        remaining_next = remaining_q;
        out_data_next  = out_data;
        step_amt       = (32'(remaining_q) >= STEP) ? AMT_W'(STEP) : AMT_W'(remaining_q);

        if (kill) begin
            state_next = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        data_next      = in_data;
                        op_next        = in_op;
                        remaining_next = in_shamt;
                        if (in_shamt == '0 || op_is_reserved(in_op)) begin
                            state_next    = DONE;
                            out_data_next = in_data;
                        end else begin
                            state_next = SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    data_next      = step_result;
                    remaining_next = remaining_q - SHAMT_W'(step_amt);
                    if (remaining_next == '0) begin
                        state_next    = DONE;
                        out_data_next = step_result;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end

        in_ready_next  = (state_next == IDLE);
        out_valid_next = (state_next == DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q      <= '0;
            op_q        <= '0;
            remaining_q <= '0;
            out_data    <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
        end else begin
            data_q      <= data_next;
            op_q        <= op_next;
            remaining_q <= remaining_next;
            out_data    <= out_data_next;
            in_ready    <= in_ready_next;
            out_valid   <= out_valid_next;
        end
    end

endmodule
